// File: rtl/tpu_layer_sequencer_if.sv
// Host command and fill/load/compute controller signals for tpu_layer_sequencer.
// The master modport is the sequencer side. The slave modport is the host plus
// the controllers.
interface tpu_layer_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_weight_base;
    logic [ADDR_WIDTH-1:0] cmd_input_base;
    logic [CNT_WIDTH-1:0]  cmd_num_row;
    logic [CNT_WIDTH-1:0]  cmd_num_col;
    logic                  cmd_reuse_w;

    logic                  fill_start;
    logic [ADDR_WIDTH-1:0] fill_base_addr;
    logic [CNT_WIDTH-1:0]  fill_num_row;
    logic [CNT_WIDTH-1:0]  fill_num_col;
    logic                  fill_done;

    logic                  wload_start;
    logic                  wload_done;

    logic                  comp_start;
    logic [ADDR_WIDTH-1:0] comp_base_addr;
    logic                  comp_done;

    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        input  cmd_valid, cmd_weight_base, cmd_input_base, cmd_num_row, cmd_num_col,
               cmd_reuse_w, fill_done, wload_done, comp_done,
        output cmd_ready, fill_start, fill_base_addr, fill_num_row, fill_num_col,
               wload_start, comp_start, comp_base_addr, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_weight_base, cmd_input_base, cmd_num_row, cmd_num_col,
               cmd_reuse_w, fill_done, wload_done, comp_done,
        input  cmd_ready, fill_start, fill_base_addr, fill_num_row, fill_num_col,
               wload_start, comp_start, comp_base_addr, busy, done, err
    );
endinterface

// File: rtl/tpu_layer_sequencer.sv
// Layer sequencer: fill -> weight load -> compute, one phase at a time.
// The optional wait-phase watchdog is built only when SEQ_WATCHDOG_EN is defined.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// IDLE        | ready for a command
// FILL_START  | one-cycle start pulse to the fill controller
// FILL_WAIT   | waiting for fill_done
// LOAD_START  | one-cycle start pulse to the weight loader
// LOAD_WAIT   | waiting for wload_done
// COMP_START  | one-cycle start pulse to the compute controller
// COMP_WAIT   | waiting for comp_done
// DONE        | one-cycle layer-complete pulse
module tpu_layer_sequencer #(
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int WDOG_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    tpu_layer_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(SYS_ARR_ROWS);

    // Row and column index fields share one width, sized from the row count.
    if (SYS_ARR_COLS > SYS_ARR_ROWS) begin : g_cols_chk
        $error("SYS_ARR_COLS must not exceed SYS_ARR_ROWS");
    end
    if (WDOG_CYCLES < 2) begin : g_wdog_chk
        $error("WDOG_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL_START = 3'd1,
        ST_FILL_WAIT  = 3'd2,
        ST_LOAD_START = 3'd3,
        ST_LOAD_WAIT  = 3'd4,
        ST_COMP_START = 3'd5,
        ST_COMP_WAIT  = 3'd6,
        ST_DONE       = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic                  weights_loaded_q, weights_loaded_d;
    logic [ADDR_WIDTH-1:0] weight_base_q, weight_base_d;
    logic [ADDR_WIDTH-1:0] input_base_q, input_base_d;
    logic [CNT_W-1:0]      num_row_q, num_row_d;
    logic [CNT_W-1:0]      num_col_q, num_col_d;
    logic                  fill_start_q, fill_start_d;
    logic                  wload_start_q, wload_start_d;
    logic                  comp_start_q, comp_start_d;
    logic                  done_q, done_d;

`ifdef SEQ_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES);
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              err_q, err_d;
    logic              in_wait;
`endif

    // Next-state, command latching and registered-output decode.
    always_comb begin
        state_d          = state_q;
        weights_loaded_d = weights_loaded_q;
        weight_base_d    = weight_base_q;
        input_base_d     = input_base_q;
        num_row_d        = num_row_q;
        num_col_d        = num_col_q;
`ifdef SEQ_WATCHDOG_EN
        wdog_cnt_d       = '0;
        err_d            = 1'b0;
        in_wait          = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    weight_base_d = bus.cmd_weight_base;
                    input_base_d  = bus.cmd_input_base;
                    num_row_d     = bus.cmd_num_row;
                    num_col_d     = bus.cmd_num_col;
                    if (!bus.cmd_reuse_w) begin
                        weights_loaded_d = 1'b0;
                    end
                    if (bus.cmd_reuse_w && weights_loaded_q) begin
                        state_d = ST_COMP_START;
                    end else begin
                        state_d = ST_FILL_START;
                    end
                end
            end
            ST_FILL_START: state_d = ST_FILL_WAIT;
            ST_FILL_WAIT: begin
                if (bus.fill_done) begin
                    state_d = ST_LOAD_START;
                end
            end
            ST_LOAD_START: state_d = ST_LOAD_WAIT;
            ST_LOAD_WAIT: begin
                if (bus.wload_done) begin
                    weights_loaded_d = 1'b1;
                    state_d          = ST_COMP_START;
                end
            end
            ST_COMP_START: state_d = ST_COMP_WAIT;
            ST_COMP_WAIT: begin
                if (bus.comp_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

`ifdef SEQ_WATCHDOG_EN
        // The counter is zero in the first wait cycle and advances while the wait continues.
        // Abort on the edge where the count would reach WDOG_CYCLES-1.
        in_wait = (state_q == ST_FILL_WAIT) || (state_q == ST_LOAD_WAIT) ||
                  (state_q == ST_COMP_WAIT);
        if (in_wait && (state_d == state_q)) begin
            if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 2)) begin
                state_d          = ST_IDLE;
                weights_loaded_d = 1'b0;
                err_d            = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + 1'b1;
            end
        end
`endif

        fill_start_d  = (state_d == ST_FILL_START);
        wload_start_d = (state_d == ST_LOAD_START);
        comp_start_d  = (state_d == ST_COMP_START);
        done_d        = (state_d == ST_DONE);
    end

    // State, configuration and pulse registers; reset aborts any layer in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            weights_loaded_q <= 1'b0;
            weight_base_q    <= '0;
            input_base_q     <= '0;
            num_row_q        <= '0;
            num_col_q        <= '0;
            fill_start_q     <= 1'b0;
            wload_start_q    <= 1'b0;
            comp_start_q     <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            weights_loaded_q <= weights_loaded_d;
            weight_base_q    <= weight_base_d;
            input_base_q     <= input_base_d;
            num_row_q        <= num_row_d;
            num_col_q        <= num_col_d;
            fill_start_q     <= fill_start_d;
            wload_start_q    <= wload_start_d;
            comp_start_q     <= comp_start_d;
            done_q           <= done_d;
        end
    end

`ifdef SEQ_WATCHDOG_EN
    // Watchdog counter and abort pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            err_q      <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.cmd_ready      = (state_q == ST_IDLE);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.fill_start     = fill_start_q;
    assign bus.fill_base_addr = weight_base_q;
    assign bus.fill_num_row   = num_row_q;
    assign bus.fill_num_col   = num_col_q;
    assign bus.wload_start    = wload_start_q;
    assign bus.comp_start     = comp_start_q;
    assign bus.comp_base_addr = input_base_q;
    assign bus.done           = done_q;
endmodule
